vga_frame_ctrl: RTL and testbench

// - Source side of the board-renderer pixel interface: VGA 640x480@60 timing plus frame-synchronous game-state feed.
// - Generates the x/y scan position consumed by the renderer and registers its rrggbb result into sync-aligned output.
// - Snapshots grid/new-tile updates from game logic and commits them only at vblank start (no tearing).
// - Drives the 3-bit new-tile fade counter.

---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_sync_gen.sv | 57 +++++
 rtl/vga_frame_ctrl.sv | 147 ++++++++++++++
 tb/tb_vga_frame_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants, grid geometry and fade-FSM types
// shared by vga_sync_gen and vga_frame_ctrl.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int CELL_BITS = 4;
  localparam int CELLS     = 16;
  localparam int GRID_BITS = CELLS * CELL_BITS;

  localparam int         FADE_FRAMES = 4;
  localparam logic [2:0] FADE_START  = 3'd7;

  typedef enum logic {
    FADE_IDLE,
    FADE_FADING
  } fade_state_t;

endpackage

// File: rtl/vga_sync_gen.sv
// Scan counters and sync decode: x/y, visible, hsync_d/vsync_d (active low),
// frame_start at (0,0), commit on the last cycle before vblank.
module vga_sync_gen #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       visible,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       frame_start,
  output logic       commit
);

  localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(HT - 1);
  localparam logic [9:0] V_LAST = 10'(VT - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_LO  = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_HI  =
    10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_LO  = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_HI  =
    10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_CMT  = 10'(V_DISPLAY - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (x == H_LAST) begin
      x <= '0;
      y <= (y == V_LAST) ? '0 : y + 10'd1;
    end else begin
      x <= x + 10'd1;
    end
  end

  assign visible     = (x < H_VIS) && (y < V_VIS);
  assign hsync_d     = !((x >= HS_LO) && (x <= HS_HI));
  assign vsync_d     = !((y >= VS_LO) && (y <= VS_HI));
  assign frame_start = (x == '0) && (y == '0);
  assign commit      = (x == H_LAST) && (y == V_CMT);

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA frame controller: scan timing, registered pixel/sync out, vblank-synced grid commit.
// Ports: grid_in/new_tiles_in/update in, pixel_in in; grid, new_tiles, new_tiles_counter, x, y, frame_start, hsync, vsync, rrggbb_out out. Fade logic under TILE_FADE_EN.
module vga_frame_ctrl #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] grid_in,
  input  logic [15:0] new_tiles_in,
  input  logic        update,
  input  logic [5:0]  pixel_in,
  output logic [63:0] grid,
  output logic [15:0] new_tiles,
  output logic [2:0]  new_tiles_counter,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [5:0]  rrggbb_out
);

  logic visible;
  logic hsync_d;
  logic vsync_d;
  logic commit;

  vga_sync_gen #(
    .H_DISPLAY(H_DISPLAY),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_DISPLAY(V_DISPLAY),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .visible    (visible),
    .hsync_d    (hsync_d),
    .vsync_d    (vsync_d),
    .frame_start(frame_start),
    .commit     (commit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rrggbb_out <= '0;
    end else begin
      hsync      <= hsync_d;
      vsync      <= vsync_d;
      rrggbb_out <= visible ? pixel_in : 6'h0;
    end
  end

  logic        pending;
  logic [63:0] pend_grid;
  logic [63:0] next_grid;
  logic        commit_go;

  // An update landing on the commit cycle bypasses the pending regs.
  assign commit_go = commit && (pending || update);
  assign next_grid = update ? grid_in : pend_grid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      pend_grid <= '0;
    end else begin
      if (update) pend_grid <= grid_in;
      if (commit)      pending <= 1'b0;
      else if (update) pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         grid <= '0;
    else if (commit_go) grid <= next_grid;
  end

`ifdef TILE_FADE_EN
  localparam int FF = vga_timing_pkg::FADE_FRAMES;
  localparam int PS_W = (FF > 1) ? $clog2(FF) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(FF - 1);

  logic [15:0]   pend_new;
  logic [15:0]   next_new;
  logic [PS_W-1:0] prescaler;
  vga_timing_pkg::fade_state_t state;

  assign next_new = update ? new_tiles_in : pend_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      pend_new <= '0;
    else if (update) pend_new <= new_tiles_in;
  end

  // Fade only advances once per frame, at the commit point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= vga_timing_pkg::FADE_IDLE;
      new_tiles         <= '0;
      new_tiles_counter <= '0;
      prescaler         <= '0;
    end else if (commit_go) begin
      state             <= vga_timing_pkg::FADE_FADING;
      new_tiles         <= next_new;
      new_tiles_counter <= vga_timing_pkg::FADE_START;
      prescaler         <= '0;
    end else if (commit) begin
      unique case (state)
        vga_timing_pkg::FADE_IDLE: begin
          prescaler <= '0;
        end
        vga_timing_pkg::FADE_FADING: begin
          if (prescaler == PS_LAST) begin
            prescaler         <= '0;
            new_tiles_counter <= new_tiles_counter - 3'd1;
            if (new_tiles_counter == 3'd1)
              state <= vga_timing_pkg::FADE_IDLE;
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
      endcase
    end
  end
`else
  logic unused_new_tiles;
  assign unused_new_tiles  = ^new_tiles_in;
  assign new_tiles         = '0;
  assign new_tiles_counter = '0;
`endif

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Self-checking bench for vga_frame_ctrl on a shrunken raster.
// Reference model works from absolute cycle count and frame arithmetic.
module tb_vga_frame_ctrl;

  localparam int HD = 16, HF = 2, HS = 3, HB = 2;
  localparam int VD = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int CX = HT - 1;
  localparam int CY = VD - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] grid_in = '0;
  logic [15:0] new_tiles_in = '0;
  logic        update = 1'b0;
  logic [5:0]  pixel_in = '0;
  logic [63:0] grid;
  logic [15:0] new_tiles;
  logic [2:0]  new_tiles_counter;
  logic [9:0]  x, y;
  logic        frame_start, hsync, vsync;
  logic [5:0]  rrggbb_out;

  vga_frame_ctrl #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .grid_in(grid_in), .new_tiles_in(new_tiles_in),
    .update(update), .pixel_in(pixel_in),
    .grid(grid), .new_tiles(new_tiles),
    .new_tiles_counter(new_tiles_counter),
    .x(x), .y(y), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .rrggbb_out(rrggbb_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          n;
  bit          m_pend, m_done;
  int          m_frames;
  logic [63:0] m_pgrid, m_grid;
  logic [15:0] m_pnew, m_new;
  logic        e_hs, e_vs;
  logic [5:0]  e_rgb;

  function automatic int px_of(input int k);
    return k % HT;
  endfunction

  function automatic int py_of(input int k);
    return (k / HT) % VT;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    n = 0; m_pend = 0; m_done = 0; m_frames = 0;
    m_pgrid = '0; m_grid = '0; m_pnew = '0; m_new = '0;
    e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
  endtask

  task automatic model_edge(input bit upd, input logic [63:0] g,
                            input logic [15:0] nt, input logic [5:0] pix);
    int px, py;
    px = px_of(n);
    py = py_of(n);
    e_hs  = !(px >= HD + HF && px < HD + HF + HS);
    e_vs  = !(py >= VD + VF && py < VD + VF + VS);
    e_rgb = (px < HD && py < VD) ? pix : 6'h0;
    if (upd) begin
      m_pend = 1; m_pgrid = g; m_pnew = nt;
    end
    if (px == CX && py == CY) begin
      if (m_pend) begin
        m_grid = m_pgrid; m_new = m_pnew;
        m_done = 1; m_frames = 0; m_pend = 0;
      end else if (m_done) begin
        m_frames++;
      end
    end
    n++;
  endtask

  function automatic logic [63:0] exp_cnt();
`ifdef TILE_FADE_EN
    if (!m_done || m_frames / 4 >= 7) return 64'd0;
    return 64'(7 - m_frames / 4);
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [63:0] exp_new();
`ifdef TILE_FADE_EN
    return 64'(m_new);
`else
    return 64'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at n=%0d",
             tag, got, exp, n);
    end
  endtask

  task automatic check_all();
    chk("x", 64'(x), 64'(px_of(n)));
    chk("y", 64'(y), 64'(py_of(n)));
    chk("frame_start", 64'(frame_start),
        64'(px_of(n) == 0 && py_of(n) == 0));
    chk("hsync", 64'(hsync), 64'(e_hs));
    chk("vsync", 64'(vsync), 64'(e_vs));
    chk("rrggbb", 64'(rrggbb_out), 64'(e_rgb));
    chk("grid", grid, m_grid);
    chk("new_tiles", 64'(new_tiles), exp_new());
    chk("counter", 64'(new_tiles_counter), exp_cnt());
  endtask

  task automatic tick(input bit upd, input logic [63:0] g,
                      input logic [15:0] nt);
    update = upd;
    grid_in = g;
    new_tiles_in = nt;
    pixel_in = 6'($urandom);
    @(posedge clk);
    model_edge(upd, g, nt, pixel_in);
    #1;
    check_all();
    update = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) tick(1'b0, r64(), 16'($urandom));
  endtask

  task automatic run_to(input int tx, input int ty);
    int lim;
    lim = FRAME + 1;
    while (!(px_of(n) == tx && py_of(n) == ty) && lim > 0) begin
      tick(1'b0, r64(), 16'($urandom));
      lim--;
    end
    chk("run_to_bound", 64'(lim > 0), 64'd1);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    idle(FRAME);

    run_to(0, 3);
    tick(1'b1, 64'h1, 16'h8001);
    run_to(CX, CY);
    chk("grid_held", grid, 64'h0);
    tick(1'b0, r64(), 16'h0);
    chk("grid_commit", grid, 64'h1);

    run_to(0, 2);
    tick(1'b1, r64(), 16'($urandom));
    run_to(5, 6);
    tick(1'b1, r64(), 16'($urandom));
    run_to(0, 0);
    idle(20);

    run_to(0, 4);
    tick(1'b1, r64(), 16'($urandom));
    run_to(CX, CY);
    tick(1'b1, r64(), 16'($urandom));
    tick(1'b1, r64(), 16'($urandom));
    run_to(CX, CY);
    idle(2);

    idle(30 * FRAME);

    repeat (3 * FRAME)
      tick($urandom_range(0, 199) == 0, r64(), 16'($urandom));

    run_to(CX, CY);
    tick(1'b1, r64(), 16'($urandom));
    idle(5 * FRAME);
    run_to(7, 6);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(FRAME + 50);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
